// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_ADDR_SIZE = 4;
    localparam int DEF_CNT_W     = DEF_ADDR_SIZE + 1;

    localparam logic PRIO_PUSH = 1'b0;
    localparam logic PRIO_POP  = 1'b1;

    // Pointer increment that wraps at depth-1, so DEPTH need not be a power of two
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                            input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ram_fifo_if.sv
// Push/pop handshake and status bundle between a FIFO user and the controller.
interface ram_fifo_if
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) ();

    logic                 push_valid;
    logic [WIDTH-1:0]     push_data;
    logic                 push_ready;
    logic                 pop_req;
    logic                 pop_ready;
    logic [WIDTH-1:0]     pop_data;
    logic                 pop_data_valid;
    logic                 full;
    logic                 empty;
    logic [ADDR_SIZE:0]   count;

    modport master (
        output push_valid, push_data, pop_req,
        input  push_ready, pop_ready, pop_data, pop_data_valid,
        input  full, empty, count
    );

    modport slave (
        input  push_valid, push_data, pop_req,
        output push_ready, pop_ready, pop_data, pop_data_valid,
        output full, empty, count
    );

endinterface

// File: rtl/ram_fifo_arb.sv
// Round-robin push/pop grant; the priority bit flips only on contended cycles.
module ram_fifo_arb
    import ram_fifo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push_valid,
    input  logic pop_req,
    input  logic full,
    input  logic empty,
    output logic push_ready,
    output logic pop_ready,
    output logic push_fire,
    output logic pop_fire
);

    logic prio;
    logic push_ok;
    logic pop_ok;

    assign push_ok    = push_valid & ~full;
    assign pop_ok     = pop_req & ~empty;
    assign push_ready = ~full & ~(pop_ok & (prio == PRIO_POP));
    assign pop_ready  = ~empty & ~(push_ok & (prio == PRIO_PUSH));
    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop_req & pop_ready;

    // The granted side is always prio, so handing over means flipping it
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= PRIO_PUSH;
        end else if (push_ok & pop_ok) begin
            prio <= (prio == PRIO_PUSH) ? PRIO_POP : PRIO_PUSH;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving one synchronous dual-port RAM; never writes and
// reads the RAM in the same cycle.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk_in,
    input  logic                 reset,
    ram_fifo_if.slave            bus,
    output logic                 ram_we,
    output logic                 ram_re,
    output logic [ADDR_SIZE-1:0] ram_we_addr,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    output logic [WIDTH-1:0]     ram_din,
    input  logic [WIDTH-1:0]     ram_dout
);

    localparam int CW = ADDR_SIZE + 1;

    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 push_fire;
    logic                 pop_fire;
    logic                 rd_pend;

    assign bus.count = cnt;
    assign bus.full  = (cnt == CW'(DEPTH));
    assign bus.empty = (cnt == '0);

    ram_fifo_arb u_arb (
        .clk        (clk_in),
        .reset      (reset),
        .push_valid (bus.push_valid),
        .pop_req    (bus.pop_req),
        .full       (bus.full),
        .empty      (bus.empty),
        .push_ready (bus.push_ready),
        .pop_ready  (bus.pop_ready),
        .push_fire  (push_fire),
        .pop_fire   (pop_fire)
    );

    // rd_pend marks the cycle in which ram_dout carries the addressed word
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            cnt                <= '0;
            ram_we             <= 1'b0;
            ram_re             <= 1'b0;
            ram_we_addr        <= '0;
            ram_rd_addr        <= '0;
            ram_din            <= '0;
            rd_pend            <= 1'b0;
            bus.pop_data       <= '0;
            bus.pop_data_valid <= 1'b0;
        end else begin
            ram_we             <= push_fire;
            ram_re             <= pop_fire;
            rd_pend            <= ram_re;
            bus.pop_data_valid <= rd_pend;
            if (push_fire) begin
                ram_we_addr <= wr_ptr;
                ram_din     <= bus.push_data;
                wr_ptr      <= ADDR_SIZE'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (pop_fire) begin
                ram_rd_addr <= rd_ptr;
                rd_ptr      <= ADDR_SIZE'(ptr_inc(32'(rd_ptr), DEPTH));
            end
            if (rd_pend) begin
                bus.pop_data <= ram_dout;
            end
            unique case (1'b1)
                push_fire: cnt <= cnt + CW'(1);
                pop_fire:  cnt <= cnt - CW'(1);
                default:   cnt <= cnt;
            endcase
        end
    end

endmodule
